mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// Two-master arbiter/sequencer in front of the RAM/IO data bus. Grants one master at
// a time, decodes addr[31:28] into RAM or IO region, and sequences the access:
// sync-RAM read latency, IO wait states with timeout, and an error response for
// unmapped addresses. m0 = CPU data port, m1 = secondary master (DMA/debug).
// PARAMETERS
// RAM_ADDR    4'h2  addr[31:28] value selecting RAM
// IO_ADDR     4'h4  addr[31:28] value selecting IO
// IO_TIMEOUT  16    max io_en cycles without io_ack before error response (>=1)
// PORTS
// clk             in   1   clock, all logic on rising edge
// rst_n           in   1   synchronous reset, active-low
// m0_req/m1_req   in   1   request; held with fields stable until own ack
// m0_we/m1_we     in   1   1 = write, 0 = read
// m0_addr/m1_addr in   32  byte address
// m0_wdata/m1_wdata in 32  write data
// m0_ack/m1_ack   out  1   one-cycle completion pulse
// m0_err/m1_err   out  1   valid with ack: unmapped address or IO timeout
// m0_rdata/m1_rdata out 32 read data; valid with own ack, else 0
// bus_addr        out  32  latched address of granted access (to RAM and IO)
// bus_wdata       out  32  latched write data
// ram_en/ram_we   out  1   RAM strobe / write enable
// ram_rdata       in   32  RAM read data, valid cycle after ram_en (sync RAM)
// io_en/io_we     out  1   IO strobe / write enable, held until io_ack or timeout
// io_rdata        in   32  IO read data, sampled when io_ack=1
// io_ack          in   1   IO completion, may be high in first io_en cycle
// BEHAVIOUR
// - States: IDLE, RAM, RAM_RD, IO, RESP. Reset (rst_n=0 at edge): IDLE; all outputs
//   0; last_grant=m1 (so m0 wins first tie); wait counter 0; rdata/err regs 0.
// - IDLE: no req -> stay. One req -> grant it. Both -> grant master != last_grant.
//   On grant latch addr/we/wdata/master id, update last_grant, decode addr[31:28]:
//   RAM_ADDR -> RAM; IO_ADDR -> IO; other -> RESP with err=1, no strobe issued.
// - RAM (1 cycle): ram_en=1, ram_we=we. Write -> RESP. Read -> RAM_RD.
// - RAM_RD (1 cycle): capture ram_rdata into rdata reg -> RESP.
// - IO: io_en=1, io_we=we every cycle; counter increments per IO cycle.
//   io_ack=1 -> capture io_rdata (reads), err=0 -> RESP. io_ack=0 on IO_TIMEOUT-th
//   cycle -> err=1, rdata=0 -> RESP. io_ack wins over timeout in the same cycle.
//   Counter width $clog2(IO_TIMEOUT+1); cleared on entry to IO.
// - RESP (1 cycle): granted master's ack=1, err/rdata from regs; other master's
//   outputs 0. -> IDLE; rdata/err regs cleared.
// - Latency from req sampled in IDLE (cycle T): unmapped ack T+1; RAM write ack T+2;
//   RAM read ack T+3; IO ack T+2+N (N = wait cycles before io_ack).
// - Write ack: rdata=0. Strobes never assert outside RAM/IO; never both together.
// - Non-granted master waits (req held); no starvation: tie always alternates.
// - Reset mid-access: access abandoned, no ack/err issued, strobes 0 from next cycle.
// - req drop before ack is a protocol violation; behaviour undefined.
// TESTING
// - rst_n=0 3 cycles with both reqs high -> all outputs 0; after release m0 granted.
// - m0 read 0x2000_0010, ram_rdata=0xDEADBEEF -> ram_en only at T+1, m0_ack T+3, rdata 0xDEADBEEF, err 0.
// - m0,m1 RAM writes simultaneously, both re-request -> order m0,m1,m0,m1; ram_we=1 each; acks T+2 per access.
// - m1 read 0x4000_0004, io_ack after 3 wait cycles, io_rdata=0x55 -> io_en 4 cycles, m1_ack rdata 0x55 err 0.
// - IO read, io_ack never, IO_TIMEOUT=16 -> io_en exactly 16 cycles, ack err=1 rdata 0.
// - m0 read 0x8000_0000 -> no ram_en/io_en, m0_ack T+1 err=1; rst_n=0 mid-IO -> io_en 0, no ack.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter that decodes RAM/IO/unmapped regions and sequences
// each access (sync-RAM read latency, IO wait states with timeout, error response).
module mem_bus_arbiter #(
  parameter logic [3:0] RAM_ADDR   = 4'h2,
  parameter logic [3:0] IO_ADDR    = 4'h4,
  parameter int         IO_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  input  logic [31:0] ram_rdata_i,
  output logic        io_en_o,
  output logic        io_we_o,
  input  logic [31:0] io_rdata_i,
  input  logic        io_ack_i
);
  localparam int CW = $clog2(IO_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RAM, RAM_RD, IO, RESP} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sel, resp;
  logic [31:0] sel_addr;
  // On a tie the master that did not win last time is chosen, so neither can starve.
  assign sel = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
  assign sel_addr = sel ? m1_addr_i : m0_addr_i;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (m0_req_i || m1_req_i) begin
        gnt_d   = sel;
        last_d  = sel;
        we_d    = sel ? m1_we_i : m0_we_i;
        addr_d  = sel_addr;
        wdata_d = sel ? m1_wdata_i : m0_wdata_i;
        cnt_d   = '0;
        err_d   = (sel_addr[31:28] != RAM_ADDR) && (sel_addr[31:28] != IO_ADDR);
        state_d = sel_addr[31:28] == RAM_ADDR ? RAM : sel_addr[31:28] == IO_ADDR ? IO : RESP;
      end
      RAM: state_d = we_q ? RESP : RAM_RD;
      RAM_RD: begin
        rdata_d = ram_rdata_i;
        state_d = RESP;
      end
      IO: begin
        cnt_d = cnt_q + 1'b1;
        if (io_ack_i) begin
          rdata_d = we_q ? '0 : io_rdata_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(IO_TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign resp        = state_q == RESP;
  assign m0_ack_o    = resp && !gnt_q;
  assign m0_err_o    = resp && !gnt_q && err_q;
  assign m0_rdata_o  = (resp && !gnt_q) ? rdata_q : '0;
  assign m1_ack_o    = resp && gnt_q;
  assign m1_err_o    = resp && gnt_q && err_q;
  assign m1_rdata_o  = (resp && gnt_q) ? rdata_q : '0;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign ram_en_o    = state_q == RAM;
  assign ram_we_o    = ram_en_o && we_q;
  assign io_en_o     = state_q == IO;
  assign io_we_o     = io_en_o && we_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: per-cycle vector table for grant/decode/latency, plus hand
// sequences for IO timeout and reset in the middle of an IO access.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = 32'h1111_0000, m1_wdata = 32'h2222_0000;
  logic m0_ack, m0_err, m1_ack, m1_err, ram_en, ram_we, io_en, io_we, io_ack = 1'b0;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, ram_rdata = '0, io_rdata = '0;
  int pass_n = 0, tot_n = 0;

  mem_bus_arbiter #(.RAM_ADDR(4'h2), .IO_ADDR(4'h4), .IO_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_rdata_i(ram_rdata),
    .io_en_o(io_en), .io_we_o(io_we), .io_rdata_i(io_rdata), .io_ack_i(io_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rs, r0, w0;
    logic [31:0] a0;
    logic r1, w1;
    logic [31:0] a1, rram;
    logic iack;
    logic [31:0] iord;
    logic [71:0] exp;
  } vec_t;
  vec_t q[$];

  task automatic add(input logic rs, r0, w0, input logic [31:0] a0, input logic r1, w1,
                     input logic [31:0] a1, rram, input logic iack, input logic [31:0] iord,
                     input logic [3:0] st, input logic [1:0] s0, input logic [31:0] rd0,
                     input logic [1:0] s1, input logic [31:0] rd1);
    vec_t v;
    v.rs = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.rram = rram; v.iack = iack; v.iord = iord;
    v.exp = {st, s0, rd0, s1, rd1};
    q.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [71:0] outs();
    return {ram_en, ram_we, io_en, io_we, m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata};
  endfunction

  initial begin
    int n_io, ack_at;
    logic [31:0] a0 = 32'h2000_0010, a1 = 32'h2000_0020, b0 = 32'h2000_0100, b1 = 32'h2000_0200;
    logic [31:0] c1 = 32'h4000_0004, c0 = 32'h4000_0008, u0 = 32'h8000_0000;
    // reset with both requesting, then m0 RAM read wins the first tie
    repeat (3) add(0, 1,0,a0, 1,1,a1, 0, 0,0, 4'b0000, 2'b00,0, 2'b00,0);
    add(1, 1,0,a0, 1,1,a1, 0,            0,0, 4'b1000, 2'b00,0, 2'b00,0);
    add(1, 1,0,a0, 1,1,a1, 32'h1234_5678,0,0, 4'b0000, 2'b00,0, 2'b00,0);
    add(1, 1,0,a0, 1,1,a1, 32'hDEAD_BEEF,0,0, 4'b0000, 2'b10,32'hDEAD_BEEF, 2'b00,0);
    add(1, 0,0,a0, 1,1,a1, 0, 0,0, 4'b0000, 2'b00,0, 2'b00,0);
    add(1, 0,0,a0, 1,1,a1, 0, 0,0, 4'b1100, 2'b00,0, 2'b00,0);
    add(1, 0,0,a0, 1,1,a1, 0, 0,0, 4'b0000, 2'b00,0, 2'b10,0);
    add(1, 0,0,a0, 0,1,a1, 0, 0,0, 4'b0000, 2'b00,0, 2'b00,0);
    // simultaneous RAM writes, both re-requesting: m0, m1, m0, m1
    for (int i = 0; i < 4; i++) begin
      add(1, 1,1,b0, 1,1,b1, 0, 0,0, 4'b1100, 2'b00,0, 2'b00,0);
      add(1, 1,1,b0, 1,1,b1, 0, 0,0, 4'b0000, i[0] ? 2'b00 : 2'b10,0, i[0] ? 2'b10 : 2'b00,0);
      add(1, i<3,1,b0, i<3,1,b1, 0, 0,0, 4'b0000, 2'b00,0, 2'b00,0);
    end
    // unmapped read: error ack next cycle, no strobe
    add(1, 1,0,u0, 0,0,b1, 0, 0,0, 4'b0000, 2'b11,0, 2'b00,0);
    add(1, 0,0,u0, 0,0,b1, 0, 0,0, 4'b0000, 2'b00,0, 2'b00,0);
    // m1 IO read with 3 wait cycles
    add(1, 0,0,u0, 1,0,c1, 0, 0,32'h99, 4'b0010, 2'b00,0, 2'b00,0);
    repeat (3) add(1, 0,0,u0, 1,0,c1, 0, 0,32'h99, 4'b0010, 2'b00,0, 2'b00,0);
    add(1, 0,0,u0, 1,0,c1, 0, 1,32'h55, 4'b0000, 2'b00,0, 2'b10,32'h55);
    add(1, 0,0,u0, 0,0,c1, 0, 0,0,      4'b0000, 2'b00,0, 2'b00,0);
    // m0 IO write acked in its first cycle: write ack carries rdata 0
    add(1, 1,1,c0, 0,0,c1, 0, 0,0,      4'b0011, 2'b00,0, 2'b00,0);
    add(1, 1,1,c0, 0,0,c1, 0, 1,32'h77, 4'b0000, 2'b10,0, 2'b00,0);
    add(1, 0,1,c0, 0,0,c1, 0, 0,0,      4'b0000, 2'b00,0, 2'b00,0);

    for (int i = 0; i < q.size(); i++) begin
      rst_n = q[i].rs; m0_req = q[i].r0; m0_we = q[i].w0; m0_addr = q[i].a0;
      m1_req = q[i].r1; m1_we = q[i].w1; m1_addr = q[i].a1;
      ram_rdata = q[i].rram; io_ack = q[i].iack; io_rdata = q[i].iord;
      tick();
      chk($sformatf("vec%0d", i), 128'(outs()), 128'(q[i].exp));
    end

    // IO timeout: io_en exactly 16 cycles, error ack with rdata 0
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4000_0100; io_ack = 1'b0; io_rdata = '1;
    n_io = 0; ack_at = 0;
    for (int c = 1; c <= 40 && ack_at == 0; c++) begin
      tick();
      if (c == 1) chk("to_bus_addr", 128'(bus_addr), 128'(32'h4000_0100));
      if (io_en) n_io++;
      if (m0_ack) begin
        ack_at = c;
        chk("to_resp", 128'({m0_err, m0_rdata, m1_ack, ram_en, io_en}), 128'({1'b1, 32'h0, 3'b000}));
      end
    end
    chk("to_io_cycles", 128'(n_io), 128'(16));
    chk("to_ack_latency", 128'(ack_at), 128'(17));
    m0_req = 1'b0;
    tick();

    // reset while m1 waits on IO: access abandoned, nothing acked
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = c1;
    tick();
    chk("mid_io_en", 128'({io_en, bus_addr}), 128'({1'b1, c1}));
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_outs", 128'({outs(), bus_addr}), 128'(0));
    rst_n = 1'b1; m1_req = 1'b0;
    n_io = 0;
    repeat (3) begin
      tick();
      if (m0_ack || m1_ack || io_en || ram_en) n_io++;
    end
    chk("post_rst_quiet", 128'(n_io), 128'(0));

    // after reset the first tie goes to m0 again
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = b0; m1_req = 1'b1; m1_we = 1'b1; m1_addr = b1;
    tick();
    chk("tie_grant_m0", 128'({ram_we, bus_addr, bus_wdata}), 128'({1'b1, b0, 32'h1111_0000}));
    tick();
    chk("tie_ack_m0", 128'({m0_ack, m1_ack}), 128'(2'b10));
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
